// File: rtl/fp32_pkg.sv
// Shared IEEE-754 binary32 definitions: field widths, special exponent
// values, the canonical quiet NaN and small field classifiers.
package fp32_pkg;

  localparam int          EXP_W     = 8;
  localparam int          FRAC_W    = 23;
  localparam int          MANT_W    = FRAC_W + 1;
  localparam logic [7:0]  EXP_BIAS  = 8'd127;
  localparam logic [7:0]  EXP_MAX   = 8'd255;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // exp all ones with a non-zero fraction
  function automatic logic fp32_is_nan(input fp32_t x);
    return (x.exp == EXP_MAX) && (x.frac != {FRAC_W{1'b0}});
  endfunction

  // exp all ones with a zero fraction
  function automatic logic fp32_is_inf(input fp32_t x);
    return (x.exp == EXP_MAX) && (x.frac == {FRAC_W{1'b0}});
  endfunction

  // zero or subnormal: subnormals are flushed to zero of the same sign
  function automatic logic fp32_is_zero(input fp32_t x);
    return (x.exp == {EXP_W{1'b0}});
  endfunction

endpackage

// File: rtl/fp32_lzc.sv
// 24-bit leading-zero counter used to normalise the significand after
// an effective subtraction. An all-zero input reports 24.
module fp32_lzc (
  input  logic [23:0] i_value,
  output logic [4:0]  o_count
);

  // Scan upward so the most significant set bit is the last one to win.
  always_comb begin
    o_count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (i_value[i]) begin
        o_count = 5'(23 - i);
      end else begin
        o_count = o_count;
      end
    end
  end

endmodule

// File: rtl/float_adder_32.sv
// Single-cycle binary32 adder with registered result and flags.
// Subnormals are flushed to zero on input and output; rounding is
// round-to-nearest-even using guard/round/sticky bits.
module float_adder_32
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] out,
  output logic        NaN_flag,
  output logic        overflow_flag
);

  fp32_t              w_a;
  fp32_t              w_b;
  fp32_t              w_big;
  fp32_t              w_small;
  logic               w_a_nan;
  logic               w_b_nan;
  logic               w_a_inf;
  logic               w_b_inf;
  logic               w_a_zero;
  logic               w_b_zero;
  logic               w_a_ge_b;
  logic               w_eff_sub;
  logic [7:0]         w_exp_diff;
  logic [26:0]        w_big_sig;
  logic [26:0]        w_small_sig;
  logic [26:0]        w_small_align;
  logic               w_shift_lost;
  logic [27:0]        w_sum;
  logic [4:0]         w_lz;
  logic [26:0]        w_norm_sig;
  logic signed [9:0]  w_norm_exp;
  logic               w_round_up;
  logic [24:0]        w_mant_rnd;
  logic signed [9:0]  w_fin_exp;
  logic [22:0]        w_fin_frac;
  logic [31:0]        w_next_out;
  logic               w_next_nan;
  logic               w_next_ovf;
  logic [31:0]        r_out;
  logic               r_nan;
  logic               r_ovf;

  assign w_a      = A;
  assign w_b      = B;
  assign w_a_nan  = fp32_is_nan(w_a);
  assign w_b_nan  = fp32_is_nan(w_b);
  assign w_a_inf  = fp32_is_inf(w_a);
  assign w_b_inf  = fp32_is_inf(w_b);
  assign w_a_zero = fp32_is_zero(w_a);
  assign w_b_zero = fp32_is_zero(w_b);

  // Magnitude order on {exp,frac}; ties keep A as the larger operand.
  assign w_a_ge_b    = (A[30:0] >= B[30:0]);
  assign w_big       = w_a_ge_b ? w_a : w_b;
  assign w_small     = w_a_ge_b ? w_b : w_a;
  assign w_eff_sub   = w_big.sign ^ w_small.sign;
  assign w_exp_diff  = w_big.exp - w_small.exp;
  assign w_big_sig   = {1'b1, w_big.frac, 3'b000};
  assign w_small_sig = {1'b1, w_small.frac, 3'b000};

  // Align the smaller significand; bits shifted out fold into sticky.
  always_comb begin
    w_shift_lost  = 1'b0;
    w_small_align = 27'd0;
    if (w_exp_diff >= 8'd26) begin
      w_small_align = 27'd1;
    end else begin
      w_shift_lost  = |(w_small_sig & ((27'd1 << w_exp_diff) - 27'd1));
      w_small_align = (w_small_sig >> w_exp_diff) | {26'd0, w_shift_lost};
    end
  end

  assign w_sum = w_eff_sub ? ({1'b0, w_big_sig} - {1'b0, w_small_align})
                           : ({1'b0, w_big_sig} + {1'b0, w_small_align});

  // When the top 24 bits are zero only the guard bit can be set, so a
  // shift of 24 still lands the leading one at bit 26.
  fp32_lzc u_lzc (
    .i_value (w_sum[26:3]),
    .o_count (w_lz)
  );

  // Normalise: one right shift on carry-out, otherwise left by the LZ count.
  always_comb begin
    w_norm_sig = 27'd0;
    w_norm_exp = 10'sd0;
    if (w_sum[27]) begin
      w_norm_sig = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_norm_exp = $signed({2'b00, w_big.exp}) + 10'sd1;
    end else begin
      w_norm_sig = w_sum[26:0] << w_lz;
      w_norm_exp = $signed({2'b00, w_big.exp}) - $signed({5'd0, w_lz});
    end
  end

  assign w_round_up = w_norm_sig[2] & (w_norm_sig[3] | w_norm_sig[1] | w_norm_sig[0]);
  assign w_mant_rnd = {1'b0, w_norm_sig[26:3]} + {24'd0, w_round_up};

  // Renormalise if rounding carried out of the significand.
  always_comb begin
    w_fin_exp  = w_norm_exp;
    w_fin_frac = 23'd0;
    if (w_mant_rnd[24]) begin
      w_fin_exp  = w_norm_exp + 10'sd1;
      w_fin_frac = w_mant_rnd[23:1];
    end else begin
      w_fin_exp  = w_norm_exp;
      w_fin_frac = w_mant_rnd[22:0];
    end
  end

  // Select special-case results ahead of the finite datapath.
  always_comb begin
    w_next_out = 32'd0;
    w_next_nan = 1'b0;
    w_next_ovf = 1'b0;
    if (w_a_nan || w_b_nan) begin
      w_next_out = CANON_NAN;
      w_next_nan = 1'b1;
    end else if (w_a_inf && w_b_inf && (w_a.sign != w_b.sign)) begin
      w_next_out = CANON_NAN;
      w_next_nan = 1'b1;
    end else if (w_a_inf) begin
      w_next_out = A;
    end else if (w_b_inf) begin
      w_next_out = B;
    end else if (w_a_zero && w_b_zero) begin
      w_next_out = {w_a.sign & w_b.sign, 31'd0};
    end else if (w_a_zero) begin
      w_next_out = B;
    end else if (w_b_zero) begin
      w_next_out = A;
    end else if (w_sum == 28'd0) begin
      w_next_out = 32'd0;
    end else if (w_fin_exp >= 10'sd255) begin
      w_next_out = {w_big.sign, EXP_MAX, 23'd0};
      w_next_ovf = 1'b1;
    end else if (w_fin_exp <= 10'sd0) begin
      w_next_out = {w_big.sign, 31'd0};
    end else begin
      w_next_out = {w_big.sign, w_fin_exp[7:0], w_fin_frac};
    end
  end

  // Output register; reset overrides the datapath result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= 32'd0;
      r_nan <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_out <= w_next_out;
      r_nan <= w_next_nan;
      r_ovf <= w_next_ovf;
    end
  end

  assign out           = r_out;
  assign NaN_flag      = r_nan;
  assign overflow_flag = r_ovf;

endmodule

// File: tb/tb_float_adder_32.sv
// Self-checking bench for float_adder_32: directed vector table, a
// mid-stream reset sequence, and back-to-back random operands checked
// against a real-arithmetic reference model.
module tb_float_adder_32;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] dut_out;
  logic        dut_nan;
  logic        dut_ovf;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] o;
    logic        n;
    logic        v;
  } vec_t;

  vec_t vecs[$];

  float_adder_32 dut (
    .clk           (clk),
    .rst           (rst),
    .A             (a),
    .B             (b),
    .out           (dut_out),
    .NaN_flag      (dut_nan),
    .overflow_flag (dut_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // binary32 (normal, or zero after flush) to an exact real
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Round an exact real to binary32 RNE; returns {bits, nan, ovf}
  function automatic logic [33:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    logic [52:0] m;
    logic [24:0] q;
    logic [28:0] rem;
    if (r == 0.0) return {32'd0, 2'b00};
    d   = $realtobits(r);
    e   = int'(d[62:52]) - 1023;
    m   = {1'b1, d[51:0]};
    q   = {1'b0, m[52:29]};
    rem = m[28:0];
    if ((rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && q[0])) q = q + 25'd1;
    if (q[24]) begin
      q = q >> 1;
      e = e + 1;
    end
    e = e + 127;
    if (e >= 255) return {d[63], 8'hFF, 23'd0, 2'b01};
    if (e <= 0) return {d[63], 31'd0, 2'b00};
    return {d[63], 8'(e), q[22:0], 2'b00};
  endfunction

  // Reference sum built from the IEEE special-value rules plus real arithmetic
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic xn, yn, xi, yi, xz, yz;
    int   dx;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    xz = (x[30:23] == 8'd0);
    yz = (y[30:23] == 8'd0);
    if (xn || yn) return {32'h7FC0_0000, 2'b10};
    if (xi && yi && (x[31] != y[31])) return {32'h7FC0_0000, 2'b10};
    if (xi) return {x, 2'b00};
    if (yi) return {y, 2'b00};
    if (xz && yz) return {x[31] & y[31], 31'd0, 2'b00};
    if (xz) return {y, 2'b00};
    if (yz) return {x, 2'b00};
    dx = int'(x[30:23]) - int'(y[30:23]);
    // Beyond 25 binades the smaller term is under a quarter ulp of the larger.
    if (dx >= 26) return {x, 2'b00};
    if (dx <= -26) return {y, 2'b00};
    return r2f(f2r(x) + f2r(y));
  endfunction

  task automatic check(input string nm, input logic [31:0] eo, input logic en, input logic ev);
    n_checks++;
    if ((dut_out !== eo) || (dut_nan !== en) || (dut_ovf !== ev)) begin
      n_errors++;
      $display("FAIL %s: got out=%h nan=%b ovf=%b, expected out=%h nan=%b ovf=%b",
               nm, dut_out, dut_nan, dut_ovf, eo, en, ev);
    end
  endtask

  function automatic logic [31:0] rand_fp(input logic [7:0] near_exp);
    logic [31:0] x;
    int          sel;
    int          e;
    x   = $urandom;
    sel = $urandom_range(0, 99);
    if (sel < 4) e = 0;
    else if (sel < 8) e = 255;
    else if (sel < 14) e = $urandom_range(1, 3);
    else if (sel < 20) e = $urandom_range(250, 254);
    else if (sel < 65) begin
      e = int'(near_exp) + $urandom_range(0, 60) - 30;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
    end else e = $urandom_range(1, 254);
    x[30:23] = 8'(e);
    if ((e == 255) && ($urandom_range(0, 1) == 0)) x[22:0] = 23'd0;
    return x;
  endfunction

  initial begin
    logic [33:0] exp_r;
    logic [31:0] pa;
    logic [31:0] pb;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    a   = 32'h3F80_0000;
    b   = 32'h4000_0000;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset", 32'd0, 1'b0, 1'b0);
    rst = 1'b0;

    vecs.push_back('{32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'hFF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'hFF80_0000, 32'hFF80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'hFF80_0000, 32'd1555,      32'hFF80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'd1555,      32'hFF80_0000, 32'hFF80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 1'b0, 1'b0});
    vecs.push_back('{32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b0, 1'b1});
    vecs.push_back('{32'hFF7F_FFFF, 32'hFF7F_FFFF, 32'hFF80_0000, 1'b0, 1'b1});
    vecs.push_back('{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h3F80_0000, 32'hFFFF_FFFF, 32'h7FC0_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h7F80_0001, 32'h7F80_0000, 32'h7FC0_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0001, 32'h8000_0005, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h0080_0001, 32'h8080_0000, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'hBF80_0000, 32'hC000_0000, 32'hC040_0000, 1'b0, 1'b0});
    vecs.push_back('{32'hC040_0000, 32'h3F80_0000, 32'hC000_0000, 1'b0, 1'b0});

    // Directed table
    foreach (vecs[i]) begin
      @(negedge clk);
      a = vecs[i].a;
      b = vecs[i].b;
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].o, vecs[i].n, vecs[i].v);
    end

    // Mid-stream reset: in-flight result dropped, next op is clean
    @(negedge clk);
    a = 32'h3F80_0000; b = 32'h4000_0000;
    @(negedge clk);
    check("pre_rst", 32'h4040_0000, 1'b0, 1'b0);
    a = 32'h7F7F_FFFF; b = 32'h7F7F_FFFF; rst = 1'b1;
    @(negedge clk);
    check("mid_rst", 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    a = 32'hBF80_0000; b = 32'hC000_0000;
    @(negedge clk);
    check("post_rst", 32'hC040_0000, 1'b0, 1'b0);
    a = 32'h7F80_0000; b = 32'hFF80_0000;
    @(negedge clk);
    check("post_rst2", 32'h7FC0_0000, 1'b1, 1'b0);

    // Back-to-back random operands against the reference model
    pa = 32'd0;
    pb = 32'd0;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] na;
      logic [31:0] nb;
      na = rand_fp(8'($urandom_range(1, 254)));
      nb = rand_fp(na[30:23]);
      if ($urandom_range(0, 9) == 0) nb = {~na[31], na[30:0]};
      if ($urandom_range(0, 9) == 0) nb = {~na[31], na[30:1], ~na[0]};
      a = na;
      b = nb;
      if (i > 0) begin
        exp_r = ref_add(pa, pb);
        check($sformatf("rand %h+%h", pa, pb), exp_r[33:2], exp_r[1], exp_r[0]);
      end
      pa = na;
      pb = nb;
      @(negedge clk);
    end
    exp_r = ref_add(pa, pb);
    check($sformatf("rand %h+%h", pa, pb), exp_r[33:2], exp_r[1], exp_r[0]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
